// File: rtl/darkbus_initiator.sv
// Single-outstanding valid/ready to device_bus bridge; read latency 3 cycles from accept with a next-edge-ack responder.
// req_ready drops from accept until the response strobe has been issued; misaligned or timed-out accesses return rsp_err.
module darkbus_initiator #(
    parameter int TIMEOUT = 15
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] BUS_ADDR,
    inout  wire  [31:0] BUS_DATA,
    output logic        BUS_EN,
    output logic        BUS_RE,
    output logic        BUS_WE,
    input  logic        BUS_RACK,
    input  logic        BUS_WACK
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_en;
    logic          r_re;
    logic          r_we;
    logic          r_is_wr;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [CW-1:0] r_cnt;

    logic          w_ack;
    logic          w_last;
    logic          w_drive;

    // An ack seen in the first ACCESS cycle belongs to the previous access, so it is never taken.
    assign w_ack   = (r_cnt != '0) && (r_is_wr ? BUS_WACK : BUS_RACK);
    assign w_last  = (r_cnt == LAST);
    assign w_drive = (r_state == ST_ACCESS) && r_is_wr;

    assign BUS_DATA  = w_drive ? r_wdata : 32'bz;
    assign BUS_ADDR  = r_addr;
    assign BUS_EN    = r_en;
    assign BUS_RE    = r_re;
    assign BUS_WE    = r_we;
    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rdata;

    always_ff @(posedge XCLK) begin
        if (XRES) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_en        <= 1'b0;
            r_re        <= 1'b0;
            r_we        <= 1'b0;
            r_is_wr     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (req_valid) begin
                        r_ready <= 1'b0;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_is_wr <= req_we;
                        r_cnt   <= '0;
                        if (req_addr[1:0] != 2'b00) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rdata     <= '0;
                        end else begin
                            r_state <= ST_ACCESS;
                            r_en    <= 1'b1;
                            r_re    <= !req_we;
                            r_we    <= req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_ack || w_last) begin
                        r_state     <= ST_RESP;
                        r_en        <= 1'b0;
                        r_re        <= 1'b0;
                        r_we        <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_ack;
                        r_rdata     <= (w_ack && !r_is_wr) ? BUS_DATA : 32'h0;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_darkbus_initiator.sv
// Bench for darkbus_initiator: ROM/write responders plus a scoreboard of expected responses.
module tb_darkbus_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic xres = 1'b1;

    localparam logic [31:0] IDLE_PAT = 32'h0F0F_0F0F;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t t_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- main instance (default TIMEOUT) ----------------
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] bus_addr;
    wire  [31:0] bus_data;
    logic        bus_en, bus_re, bus_we, bus_rack, bus_wack;

    darkbus_initiator dut (
        .XCLK(clk), .XRES(xres),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .BUS_ADDR(bus_addr), .BUS_DATA(bus_data), .BUS_EN(bus_en),
        .BUS_RE(bus_re), .BUS_WE(bus_we), .BUS_RACK(bus_rack), .BUS_WACK(bus_wack)
    );

    logic [31:0] rom [0:15];
    logic        rom_rack  = 1'b0;
    logic [31:0] rom_dat   = '0;
    logic        rack_hold = 1'b0;
    logic        idle_drv  = 1'b0;
    logic [2:0]  wcnt      = '0;
    logic [31:0] wr_seen   = '0;

    always @(posedge clk) begin
        rom_rack <= bus_en && bus_re;
        rom_dat  <= rom[bus_addr[5:2]];
        if (bus_en && bus_we) wcnt <= wcnt + 3'd1;
        else                  wcnt <= '0;
        if (bus_wack) wr_seen <= bus_data;
    end
    assign bus_rack = rom_rack || rack_hold;
    assign bus_wack = (wcnt == 3'd3);
    assign bus_data = rom_rack ? rom_dat : (idle_drv ? IDLE_PAT : 32'bz);

    // ---------------- timeout instance (TIMEOUT=4) ----------------
    logic        t_req_valid = 1'b0;
    logic [31:0] t_req_addr  = '0;
    logic        t_req_ready, t_rsp_valid, t_rsp_err;
    logic [31:0] t_rsp_rdata;
    logic [31:0] t_bus_addr;
    wire  [31:0] t_bus_data;
    logic        t_bus_en, t_bus_re, t_bus_we;
    logic        t_bus_rack = 1'b0;
    logic        t_drv      = 1'b0;
    logic [31:0] t_dat      = '0;

    darkbus_initiator #(.TIMEOUT(4)) dut_to (
        .XCLK(clk), .XRES(xres),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(1'b0),
        .req_addr(t_req_addr), .req_wdata(32'h0),
        .rsp_valid(t_rsp_valid), .rsp_err(t_rsp_err), .rsp_rdata(t_rsp_rdata),
        .BUS_ADDR(t_bus_addr), .BUS_DATA(t_bus_data), .BUS_EN(t_bus_en),
        .BUS_RE(t_bus_re), .BUS_WE(t_bus_we), .BUS_RACK(t_bus_rack), .BUS_WACK(1'b0)
    );
    assign t_bus_data = t_drv ? t_dat : 32'bz;

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rsp_valid) begin
            exp_t e;
            n_tests = n_tests + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_rsp: rsp_valid=1 err=%b rdata=%h, no response expected", rsp_err, rsp_rdata);
            end else begin
                e = sb_q.pop_front();
                n_tests = n_tests + 1;
                if (rsp_err !== e.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_err: got %b expected %b", rsp_err, e.err);
                end
                if (rsp_rdata !== e.rdata) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, e.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (t_rsp_valid) begin
            exp_t e;
            n_tests = n_tests + 1;
            if (t_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL t_unexpected_rsp: rsp_valid=1 err=%b rdata=%h, no response expected", t_rsp_err, t_rsp_rdata);
            end else begin
                e = t_q.pop_front();
                n_tests = n_tests + 1;
                if (t_rsp_err !== e.err) begin
                    n_fail = n_fail + 1;
                    $display("FAIL t_rsp_err: got %b expected %b", t_rsp_err, e.err);
                end
                if (t_rsp_rdata !== e.rdata) begin
                    n_fail = n_fail + 1;
                    $display("FAIL t_rsp_rdata: got %h expected %h", t_rsp_rdata, e.rdata);
                end
            end
        end
    end

    function automatic exp_t mk(input logic err, input logic [31:0] d);
        exp_t e;
        e.err   = err;
        e.rdata = d;
        return e;
    endfunction

    // Drives a request and returns just after the edge that accepted it (start of cycle 1).
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic t_issue(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        t_req_valid = 1'b1; t_req_addr = addr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (t_req_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        t_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        xres = 1'b1; idle_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1; @(negedge clk);
        n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        n_tests++; if ({bus_en, bus_re, bus_we} !== 3'b000) begin n_fail++; $display("FAIL reset_en_re_we: got %b expected 000", {bus_en, bus_re, bus_we}); end
        n_tests++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus_addr); end
        n_tests++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL reset_rsp: got %b expected 00", {rsp_valid, rsp_err}); end
        n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
        n_tests++; if (bus_data !== IDLE_PAT) begin n_fail++; $display("FAIL reset_data_released: got %h expected %h", bus_data, IDLE_PAT); end
        @(posedge clk); #1;
        xres = 1'b0;
        @(posedge clk); #1; @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
        idle_drv = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rom_read();
        bit ok;
        sb_q.push_back(mk(1'b0, 32'hDEAD_BEEF));
        issue(1'b0, 32'h0000_000C, 32'h0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL read_accept: not accepted within 20 cycles"); end
        @(negedge clk);
        n_tests++; if ({bus_en, bus_re, bus_we} !== 3'b110) begin n_fail++; $display("FAIL read_c1_ctrl: got %b expected 110", {bus_en, bus_re, bus_we}); end
        n_tests++; if (bus_addr !== 32'h0000_000C) begin n_fail++; $display("FAIL read_c1_addr: got %h expected 0000000c", bus_addr); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL read_c1_rsp: got %b expected 0", rsp_valid); end
        @(negedge clk);
        n_tests++; if ({bus_en, bus_rack} !== 2'b11) begin n_fail++; $display("FAIL read_c2_en_rack: got %b expected 11", {bus_en, bus_rack}); end
        @(negedge clk);
        n_tests++; if ({rsp_valid, bus_en, req_ready} !== 3'b100) begin n_fail++; $display("FAIL read_c3_rsp_en_rdy: got %b expected 100", {rsp_valid, bus_en, req_ready}); end
        @(negedge clk);
        n_tests++; if ({rsp_valid, req_ready} !== 2'b01) begin n_fail++; $display("FAIL read_c4_rdy: got %b expected 01", {rsp_valid, req_ready}); end
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        bit ok;
        sb_q.push_back(mk(1'b0, 32'h0));
        issue(1'b1, 32'h0000_0010, 32'h1234_5678, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL write_accept: not accepted within 20 cycles"); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++; if ({bus_en, bus_re, bus_we} !== 3'b101) begin n_fail++; $display("FAIL write_ctrl_c%0d: got %b expected 101", c, {bus_en, bus_re, bus_we}); end
            n_tests++; if (bus_data !== 32'h1234_5678) begin n_fail++; $display("FAIL write_data_c%0d: got %h expected 12345678", c, bus_data); end
        end
        n_tests++; if (bus_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL write_addr: got %h expected 00000010", bus_addr); end
        @(posedge clk); #1;
        idle_drv = 1'b1;
        @(negedge clk);
        n_tests++; if ({bus_en, rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL write_c5_en_rsp: got %b expected 01", {bus_en, rsp_valid}); end
        n_tests++; if (bus_data !== IDLE_PAT) begin n_fail++; $display("FAIL write_data_released: got %h expected %h", bus_data, IDLE_PAT); end
        n_tests++; if (wr_seen !== 32'h1234_5678) begin n_fail++; $display("FAIL write_captured: got %h expected 12345678", wr_seen); end
        @(posedge clk); #1;
        idle_drv = 1'b0;
    endtask

    task automatic test_misaligned();
        bit ok;
        sb_q.push_back(mk(1'b1, 32'h0));
        issue(1'b0, 32'h0000_0006, 32'h0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL misal_accept: not accepted within 20 cycles"); end
        @(negedge clk);
        n_tests++; if ({rsp_valid, rsp_err, bus_en, req_ready} !== 4'b1100) begin n_fail++; $display("FAIL misal_c1: got %b expected 1100", {rsp_valid, rsp_err, bus_en, req_ready}); end
        @(negedge clk);
        n_tests++; if ({req_ready, bus_en} !== 2'b10) begin n_fail++; $display("FAIL misal_c2: got %b expected 10", {req_ready, bus_en}); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit got;
        issue(1'b0, 32'h0000_0008, 32'h0, ok);
        xres = 1'b1;
        @(negedge clk);
        n_tests++; if (bus_en !== 1'b1) begin n_fail++; $display("FAIL rmid_c1_en: got %b expected 1", bus_en); end
        @(posedge clk); #1;
        xres = 1'b0;
        @(negedge clk);
        n_tests++; if ({bus_en, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_c2: got %b expected 00", {bus_en, rsp_valid}); end
        @(posedge clk); #1;
        idle_drv = 1'b1;
        @(negedge clk);
        n_tests++; if (bus_data !== IDLE_PAT) begin n_fail++; $display("FAIL rmid_data_released: got %h expected %h", bus_data, IDLE_PAT); end
        @(posedge clk); #1;
        idle_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        sb_q.push_back(mk(1'b0, 32'h2222_7777));
        issue(1'b0, 32'h0000_0008, 32'h0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_new_accept: not accepted within 20 cycles"); end
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        n_tests++; if (!got) begin n_fail++; $display("FAIL rmid_new_rsp: got no response expected one within 10 cycles"); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok;
        sb_q.push_back(mk(1'b0, 32'h0BAD_F00D));
        issue(1'b0, 32'h0000_0000, 32'h0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_first_accept: not accepted within 20 cycles"); end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rack_hold = 1'b1;
        sb_q.push_back(mk(1'b0, 32'hC0FF_EE01));
        issue(1'b0, 32'h0000_0004, 32'h0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_second_accept: not accepted within 20 cycles"); end
        @(negedge clk);
        n_tests++; if ({bus_en, bus_rack, rsp_valid} !== 3'b110) begin n_fail++; $display("FAIL b2b_stale_c1: got %b expected 110", {bus_en, bus_rack, rsp_valid}); end
        @(negedge clk);
        n_tests++; if ({bus_en, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL b2b_c2: got %b expected 10", {bus_en, rsp_valid}); end
        @(negedge clk);
        n_tests++; if ({bus_en, rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL b2b_c3: got %b expected 01", {bus_en, rsp_valid}); end
        @(posedge clk); #1;
        rack_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        bit ok;
        t_q.push_back(mk(1'b0, 32'h5555_AAAA));
        t_issue(32'h0000_0020, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL to_read_accept: not accepted within 20 cycles"); end
        @(posedge clk); #1;
        t_bus_rack = 1'b1; t_drv = 1'b1; t_dat = 32'h5555_AAAA;
        @(posedge clk); #1;
        t_bus_rack = 1'b0; t_drv = 1'b0;
        @(negedge clk);
        n_tests++; if (t_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL to_read_rsp: got %b expected 1", t_rsp_valid); end
        @(posedge clk); #1;
        t_q.push_back(mk(1'b1, 32'h0));
        t_issue(32'h0000_0024, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL to_accept: not accepted within 20 cycles"); end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++; if ({t_bus_en, t_rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL to_en_c%0d: got %b expected 10", c, {t_bus_en, t_rsp_valid}); end
        end
        n_tests++; if ({t_bus_re, t_bus_we, t_bus_addr} !== {2'b10, 32'h0000_0024}) begin n_fail++; $display("FAIL to_ctrl_addr: got %b/%b/%h expected 1/0/00000024", t_bus_re, t_bus_we, t_bus_addr); end
        @(posedge clk); #1;
        t_bus_rack = 1'b1;
        @(negedge clk);
        n_tests++; if ({t_bus_en, t_rsp_valid} !== 2'b01) begin n_fail++; $display("FAIL to_c5: got %b expected 01", {t_bus_en, t_rsp_valid}); end
        for (int c = 6; c <= 8; c++) begin
            @(negedge clk);
            n_tests++; if ({t_bus_en, t_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL to_late_ack_c%0d: got %b expected 00", c, {t_bus_en, t_rsp_valid}); end
        end
        @(posedge clk); #1;
        t_bus_rack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + i;
        rom[0] = 32'h0BAD_F00D;
        rom[1] = 32'hC0FF_EE01;
        rom[2] = 32'h2222_7777;
        rom[3] = 32'hDEAD_BEEF;
        test_reset();
        test_rom_read();
        test_write();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        repeat (3) @(posedge clk);
        #1; @(negedge clk);
        n_tests++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
        n_tests++; if (t_q.size() != 0) begin n_fail++; $display("FAIL t_sb_drain: got %0d pending expected 0", t_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
